// File: rtl/emmc_cmd_xfer.sv
// rtl/emmc_cmd_xfer.sv - eMMC CMD-line engine: frames a command with CRC7, collects and checks the response
module emmc_cmd_xfer #(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC_MIN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [37:0]  cmd_info_i,
    input  logic [1:0]   resp_type_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    input  logic         cmd_i,
    output logic         resp_valid_o,
    output logic [127:0] resp_o,
    output logic [5:0]   resp_idx_o,
    output logic         crc_err_o,
    output logic         timeout_o,
    output logic         busy_o
);

    localparam int NCR_W = $clog2(NCR_MAX + 2);
    localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX);
    localparam logic [7:0] NCC_LAST = 8'(NCC_MIN);

    typedef enum logic [2:0] {IDLE, TX, NCR_WAIT, RX, NCC} state_t;

    // Leading zeros leave a zero-initialised CRC untouched, so shorter fields are zero-extended.
    function automatic logic [6:0] crc7(input logic [119:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    state_t             state, state_n;
    logic [1:0]         rtype, rtype_n;
    logic [7:0]         bit_cnt, bit_cnt_n, bit_cnt_inc, rx_len;
    logic [NCR_W-1:0]   ncr_cnt, ncr_cnt_n;
    logic [135:0]       sr, sr_n, rx_next;
    logic [47:0]        frame;
    logic               cmd_n, oe_n, ready_n, resp_valid_n, crc_err_n, timeout_n;
    logic [127:0]       resp_n;
    logic [5:0]         idx_n;
    logic               r1_crc_bad, r2_crc_bad;

    assign frame       = {2'b01, cmd_info_i, crc7({80'b0, 2'b01, cmd_info_i}), 1'b1};
    assign rx_next     = {sr[134:0], cmd_i};
    assign bit_cnt_inc = bit_cnt + 8'd1;
    assign rx_len      = (rtype == 2'd2) ? 8'd136 : 8'd48;
    assign r1_crc_bad  = crc7({80'b0, rx_next[47:8]}) != rx_next[7:1];
    assign r2_crc_bad  = crc7(rx_next[127:8]) != rx_next[7:1];

    always_comb begin
        state_n      = state;
        rtype_n      = rtype;
        bit_cnt_n    = bit_cnt;
        ncr_cnt_n    = ncr_cnt;
        sr_n         = sr;
        cmd_n        = cmd_o;
        oe_n         = cmd_oe_o;
        resp_valid_n = 1'b0;
        resp_n       = resp_o;
        idx_n        = resp_idx_o;
        crc_err_n    = crc_err_o;
        timeout_n    = timeout_o;
        case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_n   = TX;
                    rtype_n   = resp_type_i;
                    sr_n      = {frame[46:0], 89'b0};
                    cmd_n     = frame[47];
                    oe_n      = 1'b1;
                    bit_cnt_n = 8'd1;
                    resp_n    = '0;
                    idx_n     = '0;
                    crc_err_n = 1'b0;
                    timeout_n = 1'b0;
                end
            end
            TX: begin
                if (bit_cnt == 8'd48) begin
                    cmd_n = 1'b1;
                    if (rtype == 2'd0) begin
                        state_n   = NCC;
                        bit_cnt_n = 8'd1;
                    end else begin
                        state_n   = NCR_WAIT;
                        oe_n      = 1'b0;
                        ncr_cnt_n = '0;
                    end
                end else begin
                    cmd_n     = sr[135];
                    sr_n      = {sr[134:0], 1'b0};
                    bit_cnt_n = bit_cnt_inc;
                end
            end
            NCR_WAIT: begin
                // The first cycle after the end bit is turnaround and is never sampled.
                if (ncr_cnt != '0 && !cmd_i) begin
                    state_n   = RX;
                    bit_cnt_n = 8'd1;
                    sr_n      = '0;
                end else if (ncr_cnt == NCR_LAST) begin
                    state_n   = NCC;
                    timeout_n = 1'b1;
                    bit_cnt_n = 8'd1;
                    oe_n      = 1'b1;
                    cmd_n     = 1'b1;
                end else begin
                    ncr_cnt_n = ncr_cnt + 1'b1;
                end
            end
            RX: begin
                sr_n      = rx_next;
                bit_cnt_n = bit_cnt_inc;
                if (bit_cnt_inc == rx_len) begin
                    state_n   = NCC;
                    bit_cnt_n = 8'd1;
                    oe_n      = 1'b1;
                    cmd_n     = 1'b1;
                    if (rtype == 2'd2) begin
                        resp_n    = rx_next[127:0];
                        idx_n     = 6'h3F;
                        crc_err_n = r2_crc_bad || !rx_next[0];
                    end else begin
                        resp_n    = {96'b0, rx_next[39:8]};
                        idx_n     = (rtype == 2'd1) ? rx_next[45:40] : 6'h3F;
                        crc_err_n = !rx_next[0] || (rtype == 2'd1 && r1_crc_bad);
                    end
                end
            end
            NCC: begin
                if (bit_cnt == NCC_LAST) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end else begin
                    bit_cnt_n    = bit_cnt_inc;
                    resp_valid_n = (bit_cnt == NCC_LAST - 8'd1);
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rtype        <= '0;
            bit_cnt      <= '0;
            ncr_cnt      <= '0;
            sr           <= '0;
            cmd_o        <= 1'b1;
            cmd_oe_o     <= 1'b0;
            cmd_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_o       <= '0;
            resp_idx_o   <= '0;
            crc_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_n;
            rtype        <= rtype_n;
            bit_cnt      <= bit_cnt_n;
            ncr_cnt      <= ncr_cnt_n;
            sr           <= sr_n;
            cmd_o        <= cmd_n;
            cmd_oe_o     <= oe_n;
            cmd_ready_o  <= ready_n;
            busy_o       <= !ready_n;
            resp_valid_o <= resp_valid_n;
            resp_o       <= resp_n;
            resp_idx_o   <= idx_n;
            crc_err_o    <= crc_err_n;
            timeout_o    <= timeout_n;
        end
    end

endmodule

// File: tb/tb_emmc_cmd_xfer.sv
// tb/tb_emmc_cmd_xfer.sv - randomized bench for emmc_cmd_xfer against a frame-level reference model
module tb_emmc_cmd_xfer;
    localparam int NCR_MAX = 64;
    localparam int NCC_MIN = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [37:0]  cmd_info = '0;
    logic [1:0]   resp_type = '0;
    logic         cmd_o, cmd_oe;
    logic         cmd_i = 1'b1;
    logic         resp_valid;
    logic [127:0] resp;
    logic [5:0]   resp_idx;
    logic         crc_err, timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    emmc_cmd_xfer #(.NCR_MAX(NCR_MAX), .NCC_MIN(NCC_MIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_info_i(cmd_info), .resp_type_i(resp_type),
        .cmd_o(cmd_o), .cmd_oe_o(cmd_oe), .cmd_i(cmd_i),
        .resp_valid_o(resp_valid), .resp_o(resp), .resp_idx_o(resp_idx),
        .crc_err_o(crc_err), .timeout_o(timeout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_crc(input logic [127:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
        check("ready_wait", cmd_ready, 1'b1);
    endtask

    // mode: 0 clean response, 1 one CRC bit flipped, 2 end bit 0, 3 card silent
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input int delay, input int mode, input logic [127:0] payload);
        logic [47:0]  frame, tx;
        logic [39:0]  body;
        logic [135:0] bits;
        logic [127:0] cid, exp_resp;
        logic [5:0]   exp_idx;
        logic         exp_crc, exp_to, card;
        int           L, start, exp_done, pulses, done_cyc, oe_cnt, oe49;

        body  = {2'b01, idx, arg};
        frame = {body, ref_crc({88'b0, body}, 40), 1'b1};
        card  = (rt != 2'd0) && (mode != 3);
        L = 48; start = 0; bits = '0;
        exp_resp = '0; exp_idx = '0; exp_crc = 1'b0; exp_to = 1'b0;
        if (rt == 2'd0) begin
            exp_done = 48 + NCC_MIN;
        end else if (mode == 3) begin
            exp_done = 48 + 1 + NCR_MAX + NCC_MIN;
            exp_to   = 1'b1;
        end else begin
            start = 48 + delay;
            if (rt == 2'd1) begin
                body = {2'b01, idx, payload[31:0]};
                bits = {88'b0, body, ref_crc({88'b0, body}, 40), 1'b1};
            end else if (rt == 2'd3) begin
                bits = {88'b0, 2'b00, 6'h3F, payload[31:0], 7'h7F, 1'b1};
            end else begin
                L = 136;
                cid = payload;
                cid[7:1] = ref_crc({8'b0, cid[127:8]}, 120);
                bits = {2'b00, 6'h3F, cid[127:1], 1'b1};
            end
            if (mode == 1) bits[$urandom_range(7, 1)] ^= 1'b1;
            if (mode == 2) bits[0] = 1'b0;
            exp_done = start + L - 1 + NCC_MIN;
            exp_crc  = (mode == 2) || (mode == 1 && rt != 2'd3);
            exp_resp = (rt == 2'd2) ? bits[127:0] : {96'b0, payload[31:0]};
            exp_idx  = (rt == 2'd1) ? idx : 6'h3F;
        end

        wait_ready();
        cmd_valid = 1'b1;
        cmd_info  = {idx, arg};
        resp_type = rt;
        @(posedge clk);
        tx = '0; pulses = 0; done_cyc = -1; oe_cnt = 0; oe49 = -1;
        for (int k = 1; k <= exp_done + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                check("cleared_on_accept", {resp, resp_idx, crc_err, timeout}, '0);
            end
            cmd_i = (card && k >= start && k < start + L) ? bits[L - 1 - (k - start)] : 1'b1;
            if (k <= 48) begin
                tx = {tx[46:0], cmd_o};
                oe_cnt += int'(cmd_oe);
            end
            if (k == 49) oe49 = int'(cmd_oe);
            if (resp_valid) begin
                pulses++;
                done_cyc = k;
            end
        end
        cmd_i = 1'b1;
        check("tx_frame", tx, frame);
        check("tx_oe_cycles", oe_cnt, 48);
        check("oe_after_end", oe49, (rt == 2'd0) ? 1 : 0);
        check("resp_valid_pulses", pulses, 1);
        check("resp_valid_cycle", done_cyc, exp_done);
        check("resp", resp, exp_resp);
        check("resp_idx", resp_idx, exp_idx);
        check("crc_err", crc_err, exp_crc);
        check("timeout", timeout, exp_to);
        check("ready_after", {cmd_ready, busy}, 2'b10);
    endtask

    task automatic reset_mid_tx();
        int pulses;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_info  = {6'd17, 32'h1234_5678};
        resp_type = 2'd1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("rst_oe_before", cmd_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_oe_async", cmd_oe, 1'b0);
        check("rst_ready_async", {cmd_ready, resp_valid}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rst_no_resp_valid", pulses, 0);
        check("rst_ready_after", {cmd_ready, cmd_oe}, 2'b10);
    endtask

    task automatic held_valid();
        int pulses, readies, busy_bad;
        int pulse_cyc[$];
        wait_ready();
        cmd_valid = 1'b1;
        cmd_info  = {6'd0, 32'h0};
        resp_type = 2'd0;
        @(posedge clk);
        pulses = 0; readies = 0; busy_bad = 0;
        for (int k = 1; k <= 175; k++) begin
            @(negedge clk);
            if (k == 166) cmd_valid = 1'b0;
            if (k < 166 && cmd_ready) readies++;
            if (busy !== !cmd_ready) busy_bad++;
            if (resp_valid) begin
                pulses++;
                pulse_cyc.push_back(k);
            end
        end
        check("held_pulses", pulses, 3);
        check("held_ready_windows", readies, 2);
        check("held_busy_inverse", busy_bad, 0);
        for (int i = 0; i < pulse_cyc.size() && i < 3; i++)
            check("held_pulse_cycle", pulse_cyc[i], 48 + NCC_MIN + i * (48 + NCC_MIN + 1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cmd_ready, cmd_oe, cmd_o, resp_valid, resp, resp_idx, crc_err, timeout, busy},
              {1'b1, 1'b0, 1'b1, 1'b0, 128'b0, 6'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(6'd0,  32'h0, 2'd0, 0, 0, '0);
        run_cmd(6'd17, 32'h0, 2'd1, 5, 0, 128'h900);
        run_cmd(6'd17, 32'h0, 2'd1, 5, 1, 128'h900);
        run_cmd(6'd17, 32'h0, 2'd1, 5, 2, 128'h900);
        run_cmd(6'd13, 32'h0001_0000, 2'd1, 0, 3, '0);
        run_cmd(6'd2,  32'h0, 2'd2, 3, 0, 128'h1501_0041_3132_3334_1001_2345_6789_ABCD);
        run_cmd(6'd1,  32'h40FF_8080, 2'd3, 4, 0, 128'h80FF_8080);
        run_cmd(6'd1,  32'h40FF_8080, 2'd3, 4, 1, 128'h80FF_8080);
        run_cmd(6'd9,  32'hFFFF_0000, 2'd2, 60, 2, {$urandom, $urandom, $urandom, $urandom});

        for (int i = 0; i < 10; i++) begin
            logic [1:0] rt;
            rt = 2'($urandom_range(3, 0));
            run_cmd(6'($urandom), $urandom, rt, $urandom_range(60, 2),
                    (rt == 2'd0) ? 0 : $urandom_range(3, 0),
                    {$urandom, $urandom, $urandom, $urandom});
        end

        reset_mid_tx();
        held_valid();
        run_cmd(6'd0, 32'h0, 2'd0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
